// File: rtl/cache_tag_lookup_pkg.sv
// cache_tag_lookup_pkg: shared geometry, op/state enums and a saturating increment for the tag lookup path
package cache_tag_lookup_pkg;
  localparam int INDEX_BITS = 5;
  localparam int TAG_BITS = 21;
  localparam int WAYS_DEFAULT = 8;
  localparam int WAY_BITS = $clog2(WAYS_DEFAULT);
  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_INVAL, OP_CLEAR} op_e;
  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_UPDATE, S_CLEAR} lookup_state_e;
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return &v ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/cache_tag_lookup_plru.sv
// plru_tree: combinational tree pseudo-LRU; next_bits after touching touch_way, victim_way from plru_bits
// Ports: plru_bits (WAYS-1 node bits, root at bit 0, node n at bit n-1), touch_way, next_bits, victim_way.
// A node bit of 0 points the victim into the lower half below that node.
module plru_tree #(
  parameter int WAYS = 8
) (
  input  logic [WAYS-2:0]         plru_bits,
  input  logic [$clog2(WAYS)-1:0] touch_way,
  output logic [WAYS-2:0]         next_bits,
  output logic [$clog2(WAYS)-1:0] victim_way
);
  localparam int WB = $clog2(WAYS);
  logic [WB:0] p, v;
  logic b;
  always_comb begin
    p = {1'b1, touch_way};
    next_bits = plru_bits;
    for (int l = 0; l < WB; l++)
      for (int n = 1; n < WAYS; n++)
        if (n == int'(p >> (WB - l))) next_bits[n-1] = ~p[WB-1-l];
    v = {{WB{1'b0}}, 1'b1};
    b = 1'b0;
    for (int l = 0; l < WB; l++) begin
      b = 1'b0;
      for (int n = 1; n < WAYS; n++)
        if (n == int'(v)) b = plru_bits[n-1];
      v = {v[WB-1:0], b};
    end
    victim_way = v[WB-1:0];
  end
endmodule

// File: rtl/cache_tag_lookup.sv
// cache_tag_lookup: set-associative tag store resolving hit/miss, PLRU victim, fill and dirty eviction
// Ports: clk, rst (sync, active-high); req_valid/req_ready/req_op/req_tag/req_index request;
//   rsp_valid/rsp_hit/rsp_way/rsp_evict/rsp_evict_tag one-cycle response.
// Define CACHE_STATS_EN to add saturating 32-bit stat_reads/writes/hits/misses/evicts outputs.
import cache_tag_lookup_pkg::*;
module cache_tag_lookup #(
  parameter int WAYS = WAYS_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  op_e                     req_op,
  input  logic [TAG_BITS-1:0]     req_tag,
  input  logic [INDEX_BITS-1:0]   req_index,
  output logic                    rsp_valid,
  output logic                    rsp_hit,
  output logic [$clog2(WAYS)-1:0] rsp_way,
  output logic                    rsp_evict,
  output logic [TAG_BITS-1:0]     rsp_evict_tag
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]             stat_reads,
  output logic [31:0]             stat_writes,
  output logic [31:0]             stat_hits,
  output logic [31:0]             stat_misses,
  output logic [31:0]             stat_evicts
`endif
);
  localparam int WB = $clog2(WAYS);
  localparam int SETS = 2 ** INDEX_BITS;
  lookup_state_e state;
  op_e op_r;
  logic [TAG_BITS-1:0] tag_r;
  logic [INDEX_BITS-1:0] idx_r;
  logic [WAYS-1:0] valid [SETS];
  logic [WAYS-1:0] dirty [SETS];
  logic [WAYS-2:0] plru [SETS];
  logic [TAG_BITS-1:0] tags [SETS][WAYS];
  logic [WAYS-1:0] hit_vec;
  logic [WB-1:0] hit_way, inv_way, victim, plru_victim;
  logic [WAYS-2:0] plru_next;
  logic hit, rw;
  assign req_ready = state == S_IDLE;
  assign rw = op_r == OP_READ || op_r == OP_WRITE;
  // Downward scans so the lowest matching / lowest invalid way wins.
  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      hit_vec[w] = valid[idx_r][w] && tags[idx_r][w] == tag_r;
      if (hit_vec[w]) hit_way = WB'(w);
      if (!valid[idx_r][w]) inv_way = WB'(w);
    end
    hit = |hit_vec;
    victim = &valid[idx_r] ? plru_victim : inv_way;
  end
  // Victim is read in LOOKUP; touch uses the registered response way in UPDATE.
  plru_tree #(.WAYS(WAYS)) u_plru (
    .plru_bits (plru[idx_r]),
    .touch_way (rsp_way),
    .next_bits (plru_next),
    .victim_way(plru_victim)
  );
  // idx_r doubles as the CLEAR sweep counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      rsp_valid <= 1'b0;
      rsp_hit <= 1'b0;
      rsp_way <= '0;
      rsp_evict <= 1'b0;
      rsp_evict_tag <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
        plru[s] <= '0;
      end
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: if (req_valid) begin
          op_r <= req_op;
          tag_r <= req_tag;
          idx_r <= req_op == OP_CLEAR ? '0 : req_index;
          state <= req_op == OP_CLEAR ? S_CLEAR : S_LOOKUP;
        end
        S_LOOKUP: begin
          rsp_valid <= 1'b1;
          rsp_hit <= hit;
          rsp_way <= hit ? hit_way : victim;
          rsp_evict <= !hit && rw && valid[idx_r][victim] && dirty[idx_r][victim];
          rsp_evict_tag <= tags[idx_r][victim];
          state <= S_UPDATE;
        end
        S_CLEAR: begin
          valid[idx_r] <= '0;
          dirty[idx_r] <= '0;
          plru[idx_r] <= '0;
          idx_r <= idx_r + INDEX_BITS'(1);
          if (&idx_r) begin
            rsp_valid <= 1'b1;
            rsp_hit <= 1'b0;
            rsp_way <= '0;
            rsp_evict <= 1'b0;
            state <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          if (rw) begin
            plru[idx_r] <= plru_next;
            if (!rsp_hit) begin
              valid[idx_r][rsp_way] <= 1'b1;
              dirty[idx_r][rsp_way] <= op_r == OP_WRITE;
            end else if (op_r == OP_WRITE) dirty[idx_r][rsp_way] <= 1'b1;
          end else if (op_r == OP_INVAL && rsp_hit) begin
            valid[idx_r][rsp_way] <= 1'b0;
            dirty[idx_r][rsp_way] <= 1'b0;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk)
    if (state == S_UPDATE && rw && !rsp_hit) tags[idx_r][rsp_way] <= tag_r;
`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_reads <= '0;
      stat_writes <= '0;
      stat_hits <= '0;
      stat_misses <= '0;
      stat_evicts <= '0;
    end else if (state == S_UPDATE && rw) begin
      stat_reads <= op_r == OP_READ ? sat_inc(stat_reads) : stat_reads;
      stat_writes <= op_r == OP_WRITE ? sat_inc(stat_writes) : stat_writes;
      stat_hits <= rsp_hit ? sat_inc(stat_hits) : stat_hits;
      stat_misses <= !rsp_hit ? sat_inc(stat_misses) : stat_misses;
      stat_evicts <= rsp_evict ? sat_inc(stat_evicts) : stat_evicts;
    end
  end
`endif
endmodule

// File: tb/tb_cache_tag_lookup.sv
// tb_cache_tag_lookup: directed table-driven bench for cache_tag_lookup plus CLEAR and mid-op reset sequences
module tb_cache_tag_lookup;
  import cache_tag_lookup_pkg::*;
  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0;
  op_e req_op = OP_READ;
  logic [TAG_BITS-1:0] req_tag = '0;
  logic [INDEX_BITS-1:0] req_index = '0;
  logic req_ready, rsp_valid, rsp_hit, rsp_evict;
  logic [2:0] rsp_way;
  logic [TAG_BITS-1:0] rsp_evict_tag;
`ifdef CACHE_STATS_EN
  logic [31:0] stat_reads, stat_writes, stat_hits, stat_misses, stat_evicts;
`endif
  cache_tag_lookup #(.WAYS(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_tag(req_tag), .req_index(req_index), .rsp_valid(rsp_valid), .rsp_hit(rsp_hit),
    .rsp_way(rsp_way), .rsp_evict(rsp_evict), .rsp_evict_tag(rsp_evict_tag)
`ifdef CACHE_STATS_EN
    , .stat_reads(stat_reads), .stat_writes(stat_writes), .stat_hits(stat_hits),
    .stat_misses(stat_misses), .stat_evicts(stat_evicts)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    op_e op;
    logic [TAG_BITS-1:0] tag;
    logic [INDEX_BITS-1:0] idx;
    logic hit;
    logic [2:0] way;
    logic ev;
    logic [TAG_BITS-1:0] etag;
  } vec_t;
  vec_t vecs[$];
  int passed = 0, total = 0;
  function automatic void add(op_e op, int tag, int idx, bit hit, int way, bit ev, int etag);
    vecs.push_back('{op, TAG_BITS'(tag), INDEX_BITS'(idx), hit, 3'(way), ev, TAG_BITS'(etag)});
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask
  // Issue one request from IDLE; returns cycles from accept to rsp_valid and cycles with ready low before it.
  task automatic issue(input op_e op, input int tag, input int idx, output int lat, output int lo);
    @(negedge clk);
    for (int k = 0; k < 50 && !req_ready; k++) @(negedge clk);
    req_valid = 1'b1;
    req_op = op;
    req_tag = TAG_BITS'(tag);
    req_index = INDEX_BITS'(idx);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = -1;
    lo = 0;
    for (int c = 1; c <= 40; c++) begin
      if (rsp_valid) begin
        lat = c;
        break;
      end
      lo += int'(!req_ready);
      @(posedge clk);
      #1;
    end
  endtask
  task automatic req_chk(input string nm, input op_e op, input int tag, input int idx,
                         input bit hit, input int way);
    int lat, lo;
    issue(op, tag, idx, lat, lo);
    check({nm, "_lat"}, lat, 2);
    check({nm, "_hit"}, 32'(rsp_hit), 32'(hit));
    check({nm, "_way"}, 32'(rsp_way), way);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int lat, lo, cnt;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 1);
    check("rst_valid", 32'(rsp_valid), 0);
    check("rst_hit", 32'(rsp_hit), 0);
    check("rst_way", 32'(rsp_way), 0);
    check("rst_evict", 32'(rsp_evict), 0);
    add(OP_READ, 'h1, 3, 0, 0, 0, 0);
    add(OP_READ, 'h1, 3, 1, 0, 0, 0);
    for (int w = 0; w < 8; w++) add(OP_READ, 'h10 + w, 5, 0, w, 0, 0);
    add(OP_READ, 'h18, 5, 0, 0, 0, 0);
    add(OP_READ, 'h10, 5, 0, 4, 0, 0);
    add(OP_WRITE, 'h20, 2, 0, 0, 0, 0);
    for (int w = 1; w < 8; w++) add(OP_READ, 'h20 + w, 2, 0, w, 0, 0);
    add(OP_READ, 'h28, 2, 0, 0, 1, 'h20);
    add(OP_WRITE, 'h28, 2, 1, 0, 0, 0);
    add(OP_READ, 'h5, 1, 0, 0, 0, 0);
    add(OP_INVAL, 'h5, 1, 1, 0, 0, 0);
    add(OP_INVAL, 'h5, 1, 0, 0, 0, 0);
    add(OP_READ, 'h5, 1, 0, 0, 0, 0);
    foreach (vecs[i]) begin
      issue(vecs[i].op, int'(vecs[i].tag), int'(vecs[i].idx), lat, lo);
      check($sformatf("v%0d_lat", i), lat, 2);
      check($sformatf("v%0d_hit", i), 32'(rsp_hit), 32'(vecs[i].hit));
      check($sformatf("v%0d_way", i), 32'(rsp_way), 32'(vecs[i].way));
      check($sformatf("v%0d_evict", i), 32'(rsp_evict), 32'(vecs[i].ev));
      if (vecs[i].ev) check($sformatf("v%0d_etag", i), 32'(rsp_evict_tag), 32'(vecs[i].etag));
    end
    req_chk("fill0", OP_READ, 'h30, 0, 0, 0);
    req_chk("fill31", OP_READ, 'h31, 31, 0, 0);
    issue(OP_CLEAR, 0, 0, lat, lo);
    check("clr_lat", lat, 33);
    check("clr_ready_low", lo, 32);
    check("clr_hit", 32'(rsp_hit), 0);
    check("clr_way", 32'(rsp_way), 0);
    check("clr_evict", 32'(rsp_evict), 0);
    @(posedge clk);
    #1;
    check("clr_one_pulse", 32'(rsp_valid), 0);
    check("clr_ready_back", 32'(req_ready), 1);
    req_chk("post_clr0", OP_READ, 'h30, 0, 0, 0);
    req_chk("post_clr31", OP_READ, 'h31, 31, 0, 0);
    req_chk("post_clr3", OP_READ, 'h1, 3, 0, 0);
    req_chk("post_clr2", OP_READ, 'h28, 2, 0, 0);
    req_chk("pre_rst", OP_READ, 'h9, 4, 0, 0);
    @(negedge clk);
    for (int k = 0; k < 50 && !req_ready; k++) @(negedge clk);
    req_valid = 1'b1;
    req_op = OP_READ;
    req_tag = TAG_BITS'('h3);
    req_index = INDEX_BITS'(4);
    @(posedge clk);
    #1 req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      cnt += int'(rsp_valid);
      @(posedge clk);
      #1;
    end
    check("abort_no_rsp", cnt, 0);
    check("abort_ready", 32'(req_ready), 1);
    req_chk("after_rst", OP_READ, 'h3, 4, 0, 0);
    req_chk("after_rst_hit", OP_READ, 'h3, 4, 1, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
